// File: rtl/data_mem_responder_if.sv
// Request/response bus between the load/store unit and the data memory.
// master = load/store unit, slave = data_mem_responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one access at a time, fixed wait states.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses fault.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus,
  output logic                stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            st_q, st_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [31:0]       ld;
  logic              word_acc;
  logic              st_legal;
  logic              mis;
  logic              err;
  logic [31:0]       rsp_data;
  logic              wr_en;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              unused_addr;

  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  assign accept = (st_q == IDLE) && bus.req_valid;
  assign idx    = addr_q[ADDR_W+1:2];
  assign word   = mem[idx];

  always_comb begin
    bsel = word[7:0];
    unique case (addr_q[1:0])
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
    hsel = addr_q[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ld = word;
    case (f3_q)
      3'b000: ld = {{24{bsel[7]}}, bsel};
      3'b001: ld = {{16{hsel[15]}}, hsel};
      3'b100: ld = {24'd0, bsel};
      3'b101: ld = {16'd0, hsel};
      default: ld = word;
    endcase
  end

  // Loads with unlisted funct3 behave as LW, so they count as word accesses.
  always_comb begin
    st_legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    if (we_q)
      word_acc = (f3_q == 3'b010);
    else
      word_acc = !((f3_q == 3'b000) || (f3_q == 3'b001) ||
                   (f3_q == 3'b100) || (f3_q == 3'b101));
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               (word_acc && (addr_q[1:0] != 2'b00));
`else
  assign mis = 1'b0;
  logic unused_word_acc;
  assign unused_word_acc = word_acc;
`endif

  assign err      = we_q ? (!st_legal || mis) : mis;
  assign rsp_data = (we_q || mis) ? 32'd0 : ld;
  assign wr_en    = (st_q == RESP) && we_q && st_legal && !mis;

  always_comb begin
    be = 4'b0000;
    wd = wdata_q;
    unique case (1'b1)
      f3_q == 3'b000: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      f3_q == 3'b001: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      f3_q == 3'b010: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            st_d  = WAIT;
            cnt_d = 4'(WAIT_CYCLES - 1);
          end else begin
            st_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) st_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
      end
      if (st_q == RESP) rdata_q <= rsp_data;
    end
  end

  // wr_en needs st_q==RESP, which async reset clears, so a reset drops the store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  assign bus.req_ready = (st_q == IDLE);
  assign bus.rsp_valid = (st_q == RESP);
  assign bus.rsp_rdata = (st_q == RESP) ? rsp_data : rdata_q;
  assign bus.rsp_err   = (st_q == RESP) && err;
  assign stall         = (st_q != IDLE) || accept;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=256, WAIT_CYCLES=2).
// Build with +define+MISALIGN_TRAP_EN to exercise the fault variant.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  logic stall;
  int   checks;
  int   errors;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH(256),
    .ADDR_W(8),
    .WAIT_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic access(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output int          stl
  );
    bit done;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    rd   = 32'hx;
    er   = 1'bx;
    lat  = -1;
    stl  = 0;
    done = 0;
    #1;
    if (stall) stl++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (stall) stl++;
      if (bus.rsp_valid) begin
        rd   = bus.rsp_rdata;
        er   = bus.rsp_err;
        lat  = i;
        done = 1;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || stall !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset: ready=%b stall=%b valid=%b rdata=%h want 1 0 0 0",
               bus.req_ready, stall, bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_sw_lw;
    logic [31:0] rd;
    logic er;
    int lat, stl;
    access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 3 || stl !== 4) begin
      errors++;
      $display("FAIL sw: rdata=%h err=%b lat=%0d stall=%0d want 0 0 3 4",
               rd, er, lat, stl);
    end
    access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3 || stl !== 4) begin
      errors++;
      $display("FAIL lw: rdata=%h err=%b lat=%0d stall=%0d want deadbeef 0 3 4",
               rd, er, lat, stl);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_valid !== 1'b0 ||
        stall !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold: rdata=%h valid=%b stall=%b ready=%b want deadbeef 0 0 1",
               bus.rsp_rdata, bus.rsp_valid, stall, bus.req_ready);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd;
    logic er;
    int lat, stl;
    access(1'b1, 32'h13, 32'h12345680, 3'b000, rd, er, lat, stl);
    access(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat, stl);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      errors++;
      $display("FAIL lb: rdata=%h err=%b want ffffff80 0", rd, er);
    end
    access(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu: rdata=%h want 00000080", rd);
    end
    access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL lw_after_sb: rdata=%h want 80adbeef", rd);
    end
  endtask

  task automatic test_half;
    logic [31:0] rd;
    logic er;
    int lat, stl;
    access(1'b1, 32'h20, 32'h00005555, 3'b010, rd, er, lat, stl);
    access(1'b1, 32'h22, 32'hABCD8001, 3'b001, rd, er, lat, stl);
    access(1'b0, 32'h22, 32'h0, 3'b001, rd, er, lat, stl);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh: rdata=%h want ffff8001", rd);
    end
    access(1'b0, 32'h22, 32'h0, 3'b101, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu: rdata=%h want 00008001", rd);
    end
    access(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h80015555) begin
      errors++;
      $display("FAIL lw_after_sh: rdata=%h want 80015555", rd);
    end
    access(1'b1, 32'h20, 32'hFFFFFFFF, 3'b011, rd, er, lat, stl);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin
      errors++;
      $display("FAIL bad_store: err=%b rdata=%h lat=%0d want 1 0 3", er, rd, lat);
    end
    access(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h80015555 || er !== 1'b0) begin
      errors++;
      $display("FAIL bad_store_mem: rdata=%h err=%b want 80015555 0", rd, er);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic er;
    int lat, stl;
    access(1'b1, 32'h40, 32'hAAAAAAAA, 3'b010, rd, er, lat, stl);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h12345678;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL wait_state: ready=%b stall=%b want 0 1", bus.req_ready, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: stall=%b ready=%b valid=%b want 0 1 0",
               stall, bus.req_ready, bus.rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL dropped_store: rdata=%h want aaaaaaaa", rd);
    end
  endtask

  task automatic test_alias;
    logic [31:0] rd;
    logic er;
    int lat, stl;
    access(1'b0, 32'h410, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL alias_rd: rdata=%h want 80adbeef", rd);
    end
    access(1'b1, 32'hFFFF0444, 32'h0BADF00D, 3'b010, rd, er, lat, stl);
    access(1'b0, 32'h44, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL alias_wr: rdata=%h want 0badf00d", rd);
    end
  endtask

  task automatic test_held_valid;
    int pulses, readies, first;
    pulses  = 0;
    readies = 0;
    first   = -1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'b010;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.rsp_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (bus.req_ready) readies++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (pulses !== 3 || readies !== 3 || first !== 3) begin
      errors++;
      $display("FAIL held_valid: pulses=%0d readies=%0d first=%0d want 3 3 3",
               pulses, readies, first);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    logic [31:0] rd;
    logic er;
    int lat, stl;
`ifdef MISALIGN_TRAP_EN
    access(1'b0, 32'h11, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin
      errors++;
      $display("FAIL mis_lw: err=%b rdata=%h lat=%0d want 1 0 3", er, rd, lat);
    end
    access(1'b1, 32'h12, 32'h11111111, 3'b010, rd, er, lat, stl);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL mis_sw: err=%b want 1", er);
    end
    access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL mis_sw_mem: rdata=%h err=%b want 80adbeef 0", rd, er);
    end
`else
    access(1'b0, 32'h11, 32'h0, 3'b010, rd, er, lat, stl);
    checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL mis_lw: err=%b rdata=%h want 0 80adbeef", er, rd);
    end
    access(1'b0, 32'h23, 32'h0, 3'b101, rd, er, lat, stl);
    checks++;
    if (er !== 1'b0 || rd !== 32'h00008001) begin
      errors++;
      $display("FAIL mis_lhu: err=%b rdata=%h want 0 00008001", er, rd);
    end
`endif
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    #15 rst = 1'b1;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_misalign();
    test_reset_mid();
    test_alias();
    test_held_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
